// File: rtl/pong_collision_unit.sv
// Collision and scoring unit for Pong: evaluates ball position on each frame tick,
// emits registered paddle/wall/miss pulses, tracks scores and sequences serve/game-over.
module pong_collision_unit #(
  parameter int FIELD_H        = 64,
  parameter int LEFT_PADDLE_X  = 2,
  parameter int RIGHT_PADDLE_X = 61,
  parameter int PADDLE_H       = 8,
  parameter int HOLDOFF        = 4,
  parameter int WIN_SCORE      = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic [5:0] bx,
  input  logic [5:0] by,
  input  logic       bx_dir,
  input  logic       by_dir,
  input  logic [5:0] lpad_y,
  input  logic [5:0] rpad_y,
  input  logic       serve_ack,
  output logic       paddle_collision,
  output logic       wall_collision,
  output logic       miss_left,
  output logic       miss_right,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic       serve_req,
  output logic       game_over
);

  localparam int HW = $clog2(HOLDOFF + 1);

  typedef enum logic [1:0] {
    PLAY       = 2'd0,
    SERVE_WAIT = 2'd1,
    GAME_OVER  = 2'd2
  } state_t;

  state_t        state;
  logic [HW-1:0] pad_hold;
  logic [HW-1:0] wall_hold;

  logic [6:0] by_w;
  logic [6:0] lbot;
  logic [6:0] rbot;
  logic       lhit_raw;
  logic       rhit_raw;
  logic       pad_fire;
  logic       wall_fire;
  logic       mleft;
  logic       mright;
  logic [3:0] score_l_inc;
  logic [3:0] score_r_inc;

  // Spans are computed one bit wider so a paddle near the bottom clips instead of wrapping.
  always_comb begin
    by_w = {1'b0, by};
    lbot = {1'b0, lpad_y} + 7'(PADDLE_H - 1);
    rbot = {1'b0, rpad_y} + 7'(PADDLE_H - 1);
    if (lbot > 7'(FIELD_H - 1)) begin
      lbot = 7'(FIELD_H - 1);
    end else begin
      lbot = lbot;
    end
    if (rbot > 7'(FIELD_H - 1)) begin
      rbot = 7'(FIELD_H - 1);
    end else begin
      rbot = rbot;
    end
    lhit_raw = !bx_dir && (bx <= 6'(LEFT_PADDLE_X)) &&
               (by_w >= {1'b0, lpad_y}) && (by_w <= lbot);
    rhit_raw = bx_dir && (bx >= 6'(RIGHT_PADDLE_X)) &&
               (by_w >= {1'b0, rpad_y}) && (by_w <= rbot);
    pad_fire  = (lhit_raw || rhit_raw) && (pad_hold == '0);
    wall_fire = ((by == 6'd0) && !by_dir) || ((by == 6'(FIELD_H - 1)) && by_dir);
    wall_fire = wall_fire && (wall_hold == '0);
    // A geometric paddle hit always saves the ball, even when its pulse is held off.
    mleft  = (bx == 6'd0)  && !bx_dir && !lhit_raw;
    mright = (bx == 6'd63) && bx_dir  && !rhit_raw;
    score_l_inc = score_l + 4'd1;
    score_r_inc = score_r + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= PLAY;
      pad_hold         <= '0;
      wall_hold        <= '0;
      paddle_collision <= 1'b0;
      wall_collision   <= 1'b0;
      miss_left        <= 1'b0;
      miss_right       <= 1'b0;
      score_l          <= 4'd0;
      score_r          <= 4'd0;
      serve_req        <= 1'b0;
      game_over        <= 1'b0;
    end else begin
      paddle_collision <= 1'b0;
      wall_collision   <= 1'b0;
      miss_left        <= 1'b0;
      miss_right       <= 1'b0;
      case (state)
        PLAY: begin
          if (frame_tick) begin
            paddle_collision <= pad_fire;
            wall_collision   <= wall_fire;
            miss_left        <= mleft;
            miss_right       <= mright;
            if (pad_fire)
              pad_hold <= HW'(HOLDOFF);
            else if (pad_hold != '0)
              pad_hold <= pad_hold - HW'(1);
            if (wall_fire)
              wall_hold <= HW'(HOLDOFF);
            else if (wall_hold != '0)
              wall_hold <= wall_hold - HW'(1);
            if (mleft || mright) begin
              if (mleft)
                score_r <= score_r_inc;
              else
                score_l <= score_l_inc;
              if ((mleft  && (score_r_inc == 4'(WIN_SCORE))) ||
                  (mright && (score_l_inc == 4'(WIN_SCORE)))) begin
                state     <= GAME_OVER;
                game_over <= 1'b1;
              end else begin
                state     <= SERVE_WAIT;
                serve_req <= 1'b1;
                pad_hold  <= '0;
                wall_hold <= '0;
              end
            end
          end
        end
        SERVE_WAIT: begin
          if (serve_ack) begin
            state     <= PLAY;
            serve_req <= 1'b0;
          end
        end
        GAME_OVER: begin
          state <= GAME_OVER;
        end
        default: begin
          state <= PLAY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pong_collision_unit.sv
// Self-checking bench for pong_collision_unit: expected output snapshots are queued
// as stimulus is driven and compared one cycle later.
module tb_pong_collision_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic [5:0] bx = 6'd31;
  logic [5:0] by = 6'd31;
  logic       bx_dir = 1'b1;
  logic       by_dir = 1'b1;
  logic [5:0] lpad_y = 6'd28;
  logic [5:0] rpad_y = 6'd28;
  logic       serve_ack = 1'b0;
  logic       paddle_collision;
  logic       wall_collision;
  logic       miss_left;
  logic       miss_right;
  logic [3:0] score_l;
  logic [3:0] score_r;
  logic       serve_req;
  logic       game_over;

  int checks = 0;
  int errors = 0;
  logic [13:0] sbq[$];
  logic [13:0] got;
  logic [13:0] exp_v;

  pong_collision_unit dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick),
    .bx(bx), .by(by), .bx_dir(bx_dir), .by_dir(by_dir),
    .lpad_y(lpad_y), .rpad_y(rpad_y), .serve_ack(serve_ack),
    .paddle_collision(paddle_collision), .wall_collision(wall_collision),
    .miss_left(miss_left), .miss_right(miss_right),
    .score_l(score_l), .score_r(score_r),
    .serve_req(serve_req), .game_over(game_over)
  );

  always #5 clk = ~clk;

  // Snapshot layout: pc wc ml mr score_l score_r serve_req game_over
  function automatic logic [13:0] mk(input logic pc, input logic wc, input logic ml,
                                     input logic mr, input logic [3:0] sl, input logic [3:0] sr,
                                     input logic sq, input logic go);
    return {pc, wc, ml, mr, sl, sr, sq, go};
  endfunction

  function automatic logic [13:0] snap();
    return {paddle_collision, wall_collision, miss_left, miss_right,
            score_l, score_r, serve_req, game_over};
  endfunction

  task automatic drive(input logic ft, input logic ack, input logic rst,
                       input logic [5:0] x, input logic [5:0] y,
                       input logic xd, input logic yd,
                       input logic [5:0] lp, input logic [5:0] rp);
    frame_tick = ft; serve_ack = ack; reset = rst;
    bx = x; by = y; bx_dir = xd; by_dir = yd; lpad_y = lp; rpad_y = rp;
    @(posedge clk);
    #1;
    frame_tick = 1'b0; serve_ack = 1'b0; reset = 1'b0;
  endtask

  task automatic neutral_ticks(input int n, input logic [3:0] sl, input logic [3:0] sr);
    for (int i = 0; i < n; i++) begin
      sbq.push_back(mk(0, 0, 0, 0, sl, sr, 0, 0));
      drive(1, 0, 0, 6'd31, 6'd31, 1, 1, 6'd28, 6'd28);
      got = snap(); exp_v = sbq.pop_front(); checks++;
      if (got !== exp_v) begin errors++; $display("FAIL neutral_tick[%0d]: got %b expected %b", i, got, exp_v); end
    end
  endtask

  task automatic test_reset();
    sbq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    drive(0, 0, 1, 6'd31, 6'd31, 1, 1, 6'd28, 6'd28);
    got = snap(); exp_v = sbq.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL reset_state: got %b expected %b", got, exp_v); end
  endtask

  task automatic test_left_hit();
    sbq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
    drive(1, 0, 0, 6'd2, 6'd31, 0, 1, 6'd28, 6'd28);
    got = snap(); exp_v = sbq.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL left_hit: got %b expected %b", got, exp_v); end
    sbq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    drive(0, 0, 0, 6'd2, 6'd31, 0, 1, 6'd28, 6'd28);
    got = snap(); exp_v = sbq.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL left_hit_width: got %b expected %b", got, exp_v); end
    for (int i = 1; i <= 5; i++) begin
      sbq.push_back(mk((i == 5), 0, 0, 0, 0, 0, 0, 0));
      drive(1, 0, 0, 6'd2, 6'd31, 0, 1, 6'd28, 6'd28);
      got = snap(); exp_v = sbq.pop_front(); checks++;
      if (got !== exp_v) begin errors++; $display("FAIL left_holdoff[%0d]: got %b expected %b", i, got, exp_v); end
    end
  endtask

  task automatic test_wall_corner();
    sbq.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0));
    drive(1, 0, 0, 6'd31, 6'd0, 1, 0, 6'd28, 6'd28);
    got = snap(); exp_v = sbq.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL top_wall: got %b expected %b", got, exp_v); end
    neutral_ticks(4, 4'd0, 4'd0);
    sbq.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0));
    drive(1, 0, 0, 6'd61, 6'd63, 1, 1, 6'd28, 6'd56);
    got = snap(); exp_v = sbq.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL corner_hit: got %b expected %b", got, exp_v); end
  endtask

  task automatic test_miss_serve();
    sbq.push_back(mk(0, 0, 1, 0, 0, 1, 1, 0));
    drive(1, 0, 0, 6'd0, 6'd10, 0, 1, 6'd40, 6'd28);
    got = snap(); exp_v = sbq.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL miss_left: got %b expected %b", got, exp_v); end
    for (int i = 0; i < 2; i++) begin
      sbq.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0));
      drive(1, 0, 0, 6'd2, 6'd31, 0, 1, 6'd28, 6'd28);
      got = snap(); exp_v = sbq.pop_front(); checks++;
      if (got !== exp_v) begin errors++; $display("FAIL serve_wait_tick[%0d]: got %b expected %b", i, got, exp_v); end
    end
    sbq.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0));
    drive(0, 1, 0, 6'd31, 6'd31, 1, 1, 6'd28, 6'd28);
    got = snap(); exp_v = sbq.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL serve_ack: got %b expected %b", got, exp_v); end
    sbq.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0));
    drive(1, 0, 0, 6'd2, 6'd31, 0, 1, 6'd28, 6'd28);
    got = snap(); exp_v = sbq.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL play_after_ack: got %b expected %b", got, exp_v); end
  endtask

  task automatic test_clipping();
    neutral_ticks(4, 4'd0, 4'd1);
    sbq.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0));
    drive(1, 0, 0, 6'd61, 6'd63, 1, 0, 6'd28, 6'd60);
    got = snap(); exp_v = sbq.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL clip_hit: got %b expected %b", got, exp_v); end
    neutral_ticks(4, 4'd0, 4'd1);
    sbq.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0));
    drive(1, 0, 0, 6'd61, 6'd3, 1, 0, 6'd28, 6'd60);
    got = snap(); exp_v = sbq.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL clip_nowrap: got %b expected %b", got, exp_v); end
    sbq.push_back(mk(0, 0, 0, 1, 1, 1, 1, 0));
    drive(1, 0, 0, 6'd63, 6'd3, 1, 0, 6'd28, 6'd60);
    got = snap(); exp_v = sbq.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL clip_miss_right: got %b expected %b", got, exp_v); end
    sbq.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0));
    drive(0, 1, 0, 6'd31, 6'd31, 1, 1, 6'd28, 6'd28);
    got = snap(); exp_v = sbq.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL clip_serve_ack: got %b expected %b", got, exp_v); end
  endtask

  task automatic test_game_over();
    for (int k = 2; k <= 7; k++) begin
      sbq.push_back(mk(0, 0, 0, 1, 4'(k), 1, (k < 7), (k == 7)));
      drive(1, 0, 0, 6'd63, 6'd10, 1, 1, 6'd28, 6'd40);
      got = snap(); exp_v = sbq.pop_front(); checks++;
      if (got !== exp_v) begin errors++; $display("FAIL right_miss[%0d]: got %b expected %b", k, got, exp_v); end
      if (k < 7) begin
        sbq.push_back(mk(0, 0, 0, 0, 4'(k), 1, 0, 0));
        drive(0, 1, 0, 6'd31, 6'd31, 1, 1, 6'd28, 6'd40);
        got = snap(); exp_v = sbq.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL miss_ack[%0d]: got %b expected %b", k, got, exp_v); end
      end
    end
    for (int i = 0; i < 3; i++) begin
      sbq.push_back(mk(0, 0, 0, 0, 7, 1, 0, 1));
      drive(1, 1, 0, 6'd63, 6'd0, 1, 0, 6'd28, 6'd40);
      got = snap(); exp_v = sbq.pop_front(); checks++;
      if (got !== exp_v) begin errors++; $display("FAIL game_over_hold[%0d]: got %b expected %b", i, got, exp_v); end
    end
  endtask

  task automatic test_reset_midgame();
    sbq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    drive(0, 0, 1, 6'd31, 6'd31, 1, 1, 6'd28, 6'd28);
    got = snap(); exp_v = sbq.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL reset_from_game_over: got %b expected %b", got, exp_v); end
    sbq.push_back(mk(0, 1, 1, 0, 0, 1, 1, 0));
    drive(1, 0, 0, 6'd0, 6'd0, 0, 0, 6'd40, 6'd28);
    got = snap(); exp_v = sbq.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL wall_and_miss: got %b expected %b", got, exp_v); end
    sbq.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0));
    drive(0, 1, 0, 6'd31, 6'd31, 1, 1, 6'd28, 6'd28);
    got = snap(); exp_v = sbq.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL midgame_ack: got %b expected %b", got, exp_v); end
    sbq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    drive(1, 0, 1, 6'd31, 6'd0, 1, 0, 6'd28, 6'd28);
    got = snap(); exp_v = sbq.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL reset_with_tick: got %b expected %b", got, exp_v); end
    sbq.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0));
    drive(1, 0, 0, 6'd31, 6'd0, 1, 0, 6'd28, 6'd28);
    got = snap(); exp_v = sbq.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL play_after_reset: got %b expected %b", got, exp_v); end
  endtask

  initial begin
    test_reset();
    test_left_hit();
    test_wall_corner();
    test_miss_serve();
    test_clipping();
    test_game_over();
    test_reset_midgame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pong_collision_unit.md
# pong_collision_unit

Registered collision and scoring unit for the Pong datapath: samples ball position and direction once per frame strobe and produces the one-cycle `paddle_collision` / `wall_collision` events that the ball mover consumes. Also detects missed balls, keeps per-player scores, and sequences serve and game-over. Sits between the ball mover, the paddle controllers and the display/score logic. Field is 64×64; the ball serves from (31, 31).

## Interface
- `FIELD_H`, 64: field height in pixels; y range is 0..FIELD_H-1.
- `LEFT_PADDLE_X`, 2: x column of the left paddle face.
- `RIGHT_PADDLE_X`, 61: x column of the right paddle face.
- `PADDLE_H`, 8: paddle height in pixels, measured from the paddle top y.
- `HOLDOFF`, 4: frame ticks during which a collision class is suppressed after it fires.
- `WIN_SCORE`, 7: score at which the game ends.

Ports:
- `clk`  in  1: system clock; single clock domain.
- `reset`  in  1: synchronous, active-high.
- `frame_tick`  in  1: position-valid strobe, one cycle wide.
- `bx`, `by`  in  6 each: ball position.
- `bx_dir`  in  1: 1 = moving toward +x (right).
- `by_dir`  in  1: 1 = moving toward +y.
- `lpad_y`, `rpad_y`  in  6 each: top y of the left and right paddles.
- `serve_ack`  in  1: ball mover has re-served.
- `paddle_collision`, `wall_collision`  out  1 each: one-cycle event pulses.
- `miss_left`, `miss_right`  out  1 each: one-cycle pulse; ball passed that side.
- `score_l`, `score_r`  out  4 each: player scores.
- `serve_req`  out  1: level; a serve is required.
- `game_over`  out  1: level.

## Operation
- States: PLAY, SERVE_WAIT, GAME_OVER. Reset enters PLAY with both holdoff counters at 0.
- Detection runs only in PLAY, on cycles where `frame_tick` = 1. `frame_tick` is ignored in the other states.
- Paddle span:
  - Left span is `lpad_y` ≤ `by` ≤ `lpad_y`+PADDLE_H-1; right span uses `rpad_y` the same way.
  - Computed at 7 bits, no wrap. A span running past FIELD_H-1 is clipped there.
- Paddle hit:
  - Left: `bx_dir`=0, `bx` ≤ LEFT_PADDLE_X, `by` inside the left span.
  - Right: `bx_dir`=1, `bx` ≥ RIGHT_PADDLE_X, `by` inside the right span.
  - Masked while the paddle holdoff counter is nonzero.
- Wall hit: (`by`=0 and `by_dir`=0) or (`by`=FIELD_H-1 and `by_dir`=1). Masked while the wall holdoff counter is nonzero.
- Miss:
  - Left: `bx`=0, `bx_dir`=0, no left paddle hit on that tick. Pulses `miss_left` and increments `score_r`.
  - Right: `bx`=63, `bx_dir`=1, no right paddle hit on that tick. Pulses `miss_right` and increments `score_l`.
  - Misses are never masked by holdoff.
- Holdoff counters:
  - Each fire loads its own counter with HOLDOFF.
  - Each `frame_tick` in PLAY decrements a nonzero counter; it saturates at 0.
  - Counters are cleared on entry to SERVE_WAIT.
- Simultaneous events:
  - Paddle and wall on the same tick (corner hit): both pulses in the same cycle, both counters loaded.
  - Wall and miss on the same tick: both pulses.
- Transitions:
  - Miss with the incremented score < WIN_SCORE: go to SERVE_WAIT and set `serve_req`=1.
  - Miss with the incremented score = WIN_SCORE: go to GAME_OVER, set `game_over`=1, `serve_req` stays 0.
  - SERVE_WAIT with `serve_ack`=1: go to PLAY, `serve_req`=0.
  - `serve_ack` is ignored in PLAY and GAME_OVER.
  - GAME_OVER is left only by `reset`.
- Scores are 4 bits and never exceed WIN_SCORE.

## Timing
- Reset values:
  - All outputs 0.
  - `paddle_collision`, `wall_collision`, `miss_left`, `miss_right` = 0.
  - `score_l`, `score_r` = 0.
  - `serve_req`, `game_over` = 0.
- Latency: all outputs are registered. Event pulses assert in cycle N+1 for a `frame_tick` sampled at edge N, exactly one cycle wide.
- Score increment, `serve_req` rise and `game_over` rise occur in the same cycle as the miss pulse.
- `serve_ack` sampled at edge N: `serve_req` falls at N+1. A `frame_tick` at edge N+1 is evaluated in PLAY.
- Back-to-back `frame_tick` on consecutive cycles is legal; each tick is evaluated independently.
- `reset` mid-game, including on a `frame_tick` cycle: outputs at reset values next cycle, no pulse emitted, state PLAY.

## Test plan
- Left paddle hit:
  - Stimulus: `lpad_y`=28, `bx`=2, `by`=31, `bx_dir`=0, `frame_tick`.
  - Response: `paddle_collision`=1 for exactly one cycle, one cycle after the tick.
  - Repeat the tick at the same position: no pulse for the next 4 ticks, pulse on the 5th.
- Top wall and corner:
  - Stimulus: `by`=0, `by_dir`=0, `bx`=31 → `wall_collision` pulse only.
  - Stimulus: `by`=63, `by_dir`=1, `bx`=61, `bx_dir`=1, `rpad_y`=56 → `paddle_collision` and `wall_collision` in the same cycle.
- Miss and serve:
  - Stimulus: `bx`=0, `bx_dir`=0, `lpad_y`=40, `by`=10.
  - Response: `miss_left` pulse, `score_r`=1, `serve_req`=1.
  - Ticks while in SERVE_WAIT produce no pulses.
  - `serve_ack` → `serve_req`=0 next cycle.
- Paddle clipping: `rpad_y`=60 with `by`=63 at the right face → hit; `by`=3 → miss, no wrap.
- Game over:
  - Stimulus: seven right-side misses, with `serve_ack` between them.
  - Response: `score_l`=7 and `game_over`=1 in the same cycle, `serve_req`=0.
  - Further ticks and `serve_ack` have no effect.
- Reset mid-game: assert `reset` together with a `frame_tick` that would hit a wall → no pulse, all outputs 0 next cycle.
